// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 Set-2 scancode decoder.
// Holds prefix bytes, the discard list, the decoder FSM states and the pause skip length.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // The Pause key sends E1 followed by seven more bytes that carry no key event.
  localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK,
    ST_SKIP
  } ps2_state_e;

  // Controller status / acknowledge bytes that must never become key events.
  function automatic logic is_discard(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: is_discard = 1'b1;
      default:                                 is_discard = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_scan_ascii.sv
// Combinational Set-2 scancode to lowercase ASCII lookup.
// Unmapped codes return 0; the caller registers the result.
module ps2_scan_ascii (
  input  logic [7:0] code_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    ascii_o = 8'h00;
    case (code_i)
      8'h1C: ascii_o = 8'h61; 8'h32: ascii_o = 8'h62; 8'h21: ascii_o = 8'h63;
      8'h23: ascii_o = 8'h64; 8'h24: ascii_o = 8'h65; 8'h2B: ascii_o = 8'h66;
      8'h34: ascii_o = 8'h67; 8'h33: ascii_o = 8'h68; 8'h43: ascii_o = 8'h69;
      8'h3B: ascii_o = 8'h6A; 8'h42: ascii_o = 8'h6B; 8'h4B: ascii_o = 8'h6C;
      8'h3A: ascii_o = 8'h6D; 8'h31: ascii_o = 8'h6E; 8'h44: ascii_o = 8'h6F;
      8'h4D: ascii_o = 8'h70; 8'h15: ascii_o = 8'h71; 8'h2D: ascii_o = 8'h72;
      8'h1B: ascii_o = 8'h73; 8'h2C: ascii_o = 8'h74; 8'h3C: ascii_o = 8'h75;
      8'h2A: ascii_o = 8'h76; 8'h1D: ascii_o = 8'h77; 8'h22: ascii_o = 8'h78;
      8'h35: ascii_o = 8'h79; 8'h1A: ascii_o = 8'h7A;
      8'h45: ascii_o = 8'h30; 8'h16: ascii_o = 8'h31; 8'h1E: ascii_o = 8'h32;
      8'h26: ascii_o = 8'h33; 8'h25: ascii_o = 8'h34; 8'h2E: ascii_o = 8'h35;
      8'h36: ascii_o = 8'h36; 8'h3D: ascii_o = 8'h37; 8'h3E: ascii_o = 8'h38;
      8'h46: ascii_o = 8'h39;
      8'h29: ascii_o = 8'h20; 8'h5A: ascii_o = 8'h0D;
      8'h0E: ascii_o = 8'h60; 8'h4E: ascii_o = 8'h2D; 8'h55: ascii_o = 8'h3D;
      8'h54: ascii_o = 8'h5B; 8'h5B: ascii_o = 8'h5D; 8'h5D: ascii_o = 8'h5C;
      8'h4C: ascii_o = 8'h3B; 8'h52: ascii_o = 8'h27; 8'h41: ascii_o = 8'h2C;
      8'h49: ascii_o = 8'h2E; 8'h4A: ascii_o = 8'h2F;
      default: ascii_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// Turns the PS/2 receiver byte stream into registered key events with
// E0/F0 prefix tracking, Pause-sequence skipping and single held-key state.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_break,
  output logic [7:0]       key_ascii,
  output logic             key_down,
  output logic [CNT_W-1:0] press_count
);

  ps2_state_e       state_q;
  logic [2:0]       skip_cnt_q;
  logic             key_valid_q;
  logic [7:0]       key_code_q;
  logic             key_ext_q;
  logic             key_break_q;
  logic [7:0]       key_ascii_q;
  logic             key_down_q;
  logic [CNT_W-1:0] press_count_q;
  logic [7:0]       held_code_q;
  logic             held_ext_q;

  logic       ev_fire_d;
  logic       ev_ext_d;
  logic       ev_brk_d;
  logic       held_match;
  logic [7:0] ascii_lut;

  ps2_scan_ascii u_ascii (
    .code_i  (rx_data),
    .ascii_o (ascii_lut)
  );

  // Decide whether the byte arriving now completes a key event, and of which kind.
  always_comb begin
    ev_fire_d = 1'b0;
    ev_ext_d  = 1'b0;
    ev_brk_d  = 1'b0;
    if (rx_valid) begin
      case (state_q)
        ST_IDLE:   ev_fire_d = (rx_data != PS2_EXT) && (rx_data != PS2_BRK) &&
                               (rx_data != PS2_PAUSE) && !is_discard(rx_data);
        ST_EXT: begin
          ev_fire_d = (rx_data != PS2_EXT) && (rx_data != PS2_BRK);
          ev_ext_d  = 1'b1;
        end
        ST_BRK: begin
          ev_fire_d = 1'b1;
          ev_brk_d  = 1'b1;
        end
        ST_EXTBRK: begin
          ev_fire_d = 1'b1;
          ev_ext_d  = 1'b1;
          ev_brk_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign held_match = key_down_q && (held_code_q == rx_data) && (held_ext_q == ev_ext_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      skip_cnt_q    <= 3'd0;
      key_valid_q   <= 1'b0;
      key_code_q    <= 8'h00;
      key_ext_q     <= 1'b0;
      key_break_q   <= 1'b0;
      key_ascii_q   <= 8'h00;
      key_down_q    <= 1'b0;
      press_count_q <= '0;
      held_code_q   <= 8'h00;
      held_ext_q    <= 1'b0;
    end else begin
      key_valid_q <= ev_fire_d;
      if (rx_valid) begin
        case (state_q)
          ST_IDLE: begin
            if (rx_data == PS2_EXT) begin
              state_q <= ST_EXT;
            end else if (rx_data == PS2_BRK) begin
              state_q <= ST_BRK;
            end else if (rx_data == PS2_PAUSE) begin
              state_q    <= ST_SKIP;
              skip_cnt_q <= PS2_PAUSE_SKIP;
            end
          end
          ST_EXT: begin
            if (rx_data == PS2_BRK) begin
              state_q <= ST_EXTBRK;
            end else if (rx_data != PS2_EXT) begin
              state_q <= ST_IDLE;
            end
          end
          ST_SKIP: begin
            skip_cnt_q <= skip_cnt_q - 3'd1;
            if (skip_cnt_q <= 3'd1) begin
              state_q    <= ST_IDLE;
              skip_cnt_q <= 3'd0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
      // Extended codes have no printable meaning, so their ASCII is forced to zero.
      if (ev_fire_d) begin
        key_code_q  <= rx_data;
        key_ext_q   <= ev_ext_d;
        key_break_q <= ev_brk_d;
        key_ascii_q <= ev_ext_d ? 8'h00 : ascii_lut;
        if (!ev_brk_d) begin
          if (!held_match) begin
            held_code_q   <= rx_data;
            held_ext_q    <= ev_ext_d;
            press_count_q <= press_count_q + 1'b1;
          end
          key_down_q <= 1'b1;
        end else if (held_match) begin
          key_down_q <= 1'b0;
        end
      end
    end
  end

  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_break   = key_break_q;
  assign key_ascii   = key_ascii_q;
  assign key_down    = key_down_q;
  assign press_count = press_count_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder: directed byte sequences push expected
// key events into a queue, and a negedge monitor pops and compares each strobe.
module tb_ps2_scan_decoder;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
    logic       down;
    logic [7:0] cnt;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic [7:0] key_ascii;
  logic       key_down;
  logic [7:0] press_count;

  exp_t expQ[$];
  int   tests    = 0;
  int   failures = 0;
  logic prevValid = 1'b0;

  ps2_scan_decoder #(.CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_break   (key_break),
    .key_ascii   (key_ascii),
    .key_down    (key_down),
    .press_count (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expectEvent(input logic [7:0] code, input logic ext, input logic brk,
                             input logic [7:0] ascii, input logic down, input logic [7:0] cnt);
    exp_t e;
    e.code = code; e.ext = ext; e.brk = brk; e.ascii = ascii; e.down = down; e.cnt = cnt;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkResetState();
    checkOutput("reset key_valid", {15'd0, key_valid}, 16'd0);
    checkOutput("reset key_code", {8'd0, key_code}, 16'd0);
    checkOutput("reset key_ascii", {8'd0, key_ascii}, 16'd0);
    checkOutput("reset flags", {13'd0, key_ext, key_break, key_down}, 16'd0);
    checkOutput("reset press_count", {8'd0, press_count}, 16'd0);
  endtask

  // Monitor: every key_valid strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && key_valid) begin
      checkOutput("key_valid single cycle", {15'd0, prevValid}, 16'd0);
      if (expQ.size() == 0) begin
        tests++;
        failures++;
        $display("[TB] FAIL unexpected event: got code %0h expected no event", key_code);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("key_code", {8'd0, key_code}, {8'd0, e.code});
        checkOutput("key_ext", {15'd0, key_ext}, {15'd0, e.ext});
        checkOutput("key_break", {15'd0, key_break}, {15'd0, e.brk});
        checkOutput("key_ascii", {8'd0, key_ascii}, {8'd0, e.ascii});
        checkOutput("key_down", {15'd0, key_down}, {15'd0, e.down});
        checkOutput("press_count", {8'd0, press_count}, {8'd0, e.cnt});
      end
    end
    prevValid = key_valid;
  end

  task automatic drainQueue(input string name);
    int budget;
    budget = 50;
    while (expQ.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput({name, " pending events"}, 16'(expQ.size()), 16'd0);
    expQ.delete();
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    checkResetState();
    rst = 1'b0;
    @(negedge clk);

    expectEvent(8'h1C, 1'b0, 1'b0, 8'h61, 1'b1, 8'd1);
    applyStimulus(8'h1C);
    expectEvent(8'h1C, 1'b0, 1'b1, 8'h61, 1'b0, 8'd1);
    applyStimulus(8'hF0); applyStimulus(8'h1C);
    drainQueue("make/break");

    for (int i = 0; i < 3; i++) expectEvent(8'h1C, 1'b0, 1'b0, 8'h61, 1'b1, 8'd2);
    expectEvent(8'h1C, 1'b0, 1'b1, 8'h61, 1'b0, 8'd2);
    applyStimulus(8'h1C); applyStimulus(8'h1C); applyStimulus(8'h1C);
    applyStimulus(8'hF0); applyStimulus(8'h1C);
    drainQueue("typematic");

    expectEvent(8'h75, 1'b1, 1'b0, 8'h00, 1'b1, 8'd3);
    expectEvent(8'h75, 1'b1, 1'b1, 8'h00, 1'b0, 8'd3);
    applyStimulus(8'hE0); applyStimulus(8'h75);
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
    drainQueue("extended");

    expectEvent(8'h16, 1'b0, 1'b0, 8'h31, 1'b1, 8'd4);
    expectEvent(8'h16, 1'b0, 1'b1, 8'h31, 1'b0, 8'd4);
    applyStimulus(8'hE1); applyStimulus(8'h14); applyStimulus(8'h77); applyStimulus(8'hE1);
    applyStimulus(8'hF0); applyStimulus(8'h14); applyStimulus(8'hF0); applyStimulus(8'h77);
    applyStimulus(8'h16); applyStimulus(8'hF0); applyStimulus(8'h16);
    drainQueue("pause");

    expectEvent(8'h1C, 1'b0, 1'b0, 8'h61, 1'b1, 8'd5);
    expectEvent(8'h32, 1'b0, 1'b0, 8'h62, 1'b1, 8'd6);
    expectEvent(8'h1C, 1'b0, 1'b1, 8'h61, 1'b1, 8'd6);
    expectEvent(8'h32, 1'b0, 1'b1, 8'h62, 1'b0, 8'd6);
    applyStimulus(8'h1C); applyStimulus(8'h32);
    applyStimulus(8'hF0); applyStimulus(8'h1C);
    applyStimulus(8'hF0); applyStimulus(8'h32);
    drainQueue("rollover");

    applyStimulus(8'hAA); applyStimulus(8'hFA);
    drainQueue("discard");
    checkOutput("discard keeps count", {8'd0, press_count}, 16'd6);

    applyStimulus(8'hE0);
    pulseReset();
    checkResetState();
    expectEvent(8'h1C, 1'b0, 1'b0, 8'h61, 1'b1, 8'd1);
    expectEvent(8'h1C, 1'b0, 1'b1, 8'h61, 1'b0, 8'd1);
    applyStimulus(8'h1C); applyStimulus(8'hF0); applyStimulus(8'h1C);
    drainQueue("reset prefix");

    pulseReset();
    for (int i = 0; i < 256; i++) begin
      expectEvent(8'h05, 1'b0, 1'b0, 8'h00, 1'b1, 8'(i + 1));
      expectEvent(8'h05, 1'b0, 1'b1, 8'h00, 1'b0, 8'(i + 1));
      applyStimulus(8'h05); applyStimulus(8'hF0); applyStimulus(8'h05);
    end
    drainQueue("wrap");
    checkOutput("wrap press_count", {8'd0, press_count}, 16'd0);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
